// File: rtl/sram_bus_pkg.sv
// Shared definitions for the sram-like bus and its arbiter.
//   SZ_BYTE/SZ_HALF/SZ_WORD : access size encodings carried on *_size
//   ARB_FIXED/ARB_RR        : arbitration mode selectors
//   ch_idx_t                : channel index, wide enough for up to 8 masters
package sram_bus_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    localparam int CH_IDX_W = 3;
    typedef logic [CH_IDX_W-1:0] ch_idx_t;

endpackage

// File: rtl/sram_like_arbiter_if.sv
// Bundle of the multi-channel master side and the single slave side of the
// sram-like arbiter.
//   m_*   : NUM_CH packed request channels toward the arbiter, plus per-channel
//           addr_ok/data_ok and the broadcast read data back to the masters
//   s_*   : the single selected request toward memory and its handshake
// Modports: master (CPU-side masters), slave (memory), arb (the arbiter).
interface sram_like_arbiter_if #(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int SW = DATA_W / 8;

    logic [NUM_CH-1:0]        m_req;
    logic [NUM_CH-1:0]        m_wr;
    logic [2*NUM_CH-1:0]      m_size;
    logic [ADDR_W*NUM_CH-1:0] m_addr;
    logic [SW*NUM_CH-1:0]     m_wstrb;
    logic [DATA_W*NUM_CH-1:0] m_wdata;
    logic [NUM_CH-1:0]        m_addr_ok;
    logic [NUM_CH-1:0]        m_data_ok;
    logic [DATA_W-1:0]        m_rdata;

    logic                     s_req;
    logic                     s_wr;
    logic [1:0]               s_size;
    logic [ADDR_W-1:0]        s_addr;
    logic [SW-1:0]            s_wstrb;
    logic [DATA_W-1:0]        s_wdata;
    logic                     s_addr_ok;
    logic                     s_data_ok;
    logic [DATA_W-1:0]        s_rdata;

    modport master (
        output m_req, m_wr, m_size, m_addr, m_wstrb, m_wdata,
        input  m_addr_ok, m_data_ok, m_rdata
    );

    modport slave (
        input  s_req, s_wr, s_size, s_addr, s_wstrb, s_wdata,
        output s_addr_ok, s_data_ok, s_rdata
    );

    modport arb (
        input  m_req, m_wr, m_size, m_addr, m_wstrb, m_wdata,
        output m_addr_ok, m_data_ok, m_rdata,
        output s_req, s_wr, s_size, s_addr, s_wstrb, s_wdata,
        input  s_addr_ok, s_data_ok, s_rdata
    );

endinterface

// File: rtl/order_fifo.sv
// Small in-order FIFO remembering which channel issued each outstanding
// transaction.
//   clk, resetn : clock, asynchronous active-low reset
//   push, din   : write an entry (caller guarantees not full)
//   pop         : drop the head entry (caller guarantees not empty)
//   head        : oldest entry
//   count       : number of stored entries, 0..DEPTH
//   full, empty : count == DEPTH / count == 0
module order_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 3
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;

    // Pointers are exactly log2(DEPTH) bits so they wrap without compare.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wptr] <= din;
                wptr      <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head  = mem[rptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/sram_like_arbiter.sv
// N-channel arbiter sharing one sram-like (req/addr_ok/data_ok) memory port
// among NUM_CH masters (ch0 = instruction fetch, ch1 = data access).
//   clk, resetn : clock, asynchronous active-low reset
//   bus (arb)   : m_* master channels and s_* memory port, see interface
//   proto_err   : sticky, set when memory answers with nothing outstanding
// Request and response paths are purely combinational; responses are
// returned in acceptance order using an order FIFO of channel indices.
module sram_like_arbiter
    import sram_bus_pkg::*;
#(
    parameter int NUM_CH    = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_OUTST = 4,
    parameter int ARB_MODE  = ARB_FIXED
) (
    input  logic               clk,
    input  logic               resetn,
    sram_like_arbiter_if.arb   bus,
    output logic               proto_err
);
    localparam int SW = DATA_W / 8;
    localparam int CW = $clog2(MAX_OUTST) + 1;

    ch_idx_t        win;
    ch_idx_t        grant;
    ch_idx_t        lock_ch;
    ch_idx_t        rr_ptr;
    ch_idx_t        head;
    logic           lock_vld;
    logic           s_req_int;
    logic           accept;
    logic           pop;
    logic           fifo_full;
    logic           fifo_empty;
    logic [CW-1:0]  fifo_count;
    int             best_dist;

    // Winner among current requests; round-robin picks the requester with
    // the smallest circular distance from rr_ptr.
    always_comb begin
        win       = '0;
        best_dist = NUM_CH;
        if (ARB_MODE == ARB_RR) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (bus.m_req[i] &&
                    (((i - int'(rr_ptr)) + NUM_CH) % NUM_CH) < best_dist) begin
                    best_dist = ((i - int'(rr_ptr)) + NUM_CH) % NUM_CH;
                    win       = ch_idx_t'(i);
                end
            end
        end else begin
            for (int i = NUM_CH - 1; i >= 0; i--) begin
                if (bus.m_req[i]) begin
                    win = ch_idx_t'(i);
                end
            end
        end
    end

    // A pending (not yet accepted) request keeps the slave payload stable.
    assign grant     = lock_vld ? lock_ch : win;
    assign s_req_int = (lock_vld || (|bus.m_req)) && !fifo_full;
    assign accept    = s_req_int && bus.s_addr_ok;
    assign pop       = bus.s_data_ok && (fifo_count != '0);

    always_comb begin
        bus.s_wr    = 1'b0;
        bus.s_size  = '0;
        bus.s_addr  = '0;
        bus.s_wstrb = '0;
        bus.s_wdata = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant == ch_idx_t'(i)) begin
                bus.s_wr    = bus.m_wr[i];
                bus.s_size  = bus.m_size[2*i +: 2];
                bus.s_addr  = bus.m_addr[ADDR_W*i +: ADDR_W];
                bus.s_wstrb = bus.m_wstrb[SW*i +: SW];
                bus.s_wdata = bus.m_wdata[DATA_W*i +: DATA_W];
            end
        end
    end

    always_comb begin
        bus.m_addr_ok = '0;
        bus.m_data_ok = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            bus.m_addr_ok[i] = accept && (grant == ch_idx_t'(i));
            bus.m_data_ok[i] = pop && (head == ch_idx_t'(i));
        end
    end

    assign bus.s_req   = s_req_int;
    assign bus.m_rdata = bus.s_rdata;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lock_vld  <= 1'b0;
            lock_ch   <= '0;
            rr_ptr    <= '0;
            proto_err <= 1'b0;
        end else begin
            if (accept) begin
                lock_vld <= 1'b0;
            end else if (s_req_int) begin
                lock_vld <= 1'b1;
                lock_ch  <= grant;
            end
            if ((ARB_MODE == ARB_RR) && accept) begin
                rr_ptr <= ch_idx_t'((int'(grant) + 1) % NUM_CH);
            end
            if (bus.s_data_ok && fifo_empty) begin
                proto_err <= 1'b1;
            end
        end
    end

    order_fifo #(
        .DEPTH (MAX_OUTST),
        .WIDTH ($bits(ch_idx_t))
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (accept),
        .din    (grant),
        .pop    (pop),
        .head   (head),
        .count  (fifo_count),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Bench for sram_like_arbiter: a fixed-priority 2-channel instance driven by
// a vector table plus hand sequences (lock, ordering, error, reset), and a
// 3-channel round-robin instance.
module tb_sram_like_arbiter;
    import sram_bus_pkg::*;

    logic clk = 1'b0;
    logic resetn;
    logic err_f;
    logic err_r;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    sram_like_arbiter_if #(.NUM_CH(2), .ADDR_W(32), .DATA_W(32)) bf ();
    sram_like_arbiter_if #(.NUM_CH(3), .ADDR_W(32), .DATA_W(32)) br ();

    sram_like_arbiter #(
        .NUM_CH(2), .ADDR_W(32), .DATA_W(32), .MAX_OUTST(4), .ARB_MODE(ARB_FIXED)
    ) u_fix (
        .clk(clk), .resetn(resetn), .bus(bf), .proto_err(err_f)
    );

    sram_like_arbiter #(
        .NUM_CH(3), .ADDR_W(32), .DATA_W(32), .MAX_OUTST(8), .ARB_MODE(ARB_RR)
    ) u_rr (
        .clk(clk), .resetn(resetn), .bus(br), .proto_err(err_r)
    );

    typedef struct {
        logic [1:0]  req;
        logic        aok;
        logic        dok;
        logic [31:0] rdata;
        logic        exp_sreq;
        logic [1:0]  exp_aok;
        logic [1:0]  exp_dok;
        logic [31:0] exp_saddr;
        logic        exp_swr;
        logic        exp_err;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(logic [1:0] req, logic aok, logic dok, logic [31:0] rdata,
                                logic esreq, logic [1:0] eaok, logic [1:0] edok,
                                logic [31:0] esaddr, logic eswr, logic eerr);
        vec_t v;
        v.req = req; v.aok = aok; v.dok = dok; v.rdata = rdata;
        v.exp_sreq = esreq; v.exp_aok = eaok; v.exp_dok = edok;
        v.exp_saddr = esaddr; v.exp_swr = eswr; v.exp_err = eerr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive_f(input logic [1:0] req, input logic aok, input logic dok,
                           input logic [31:0] rdata);
        bf.m_req     = req;
        bf.s_addr_ok = aok;
        bf.s_data_ok = dok;
        bf.s_rdata   = rdata;
    endtask

    task automatic pulse_reset();
        #2 resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
    endtask

    initial begin
        // Channel payloads: ch0 word read at 0x200, ch1 half write at 0x100.
        bf.m_wr    = 2'b10;
        bf.m_size  = {SZ_HALF, SZ_WORD};
        bf.m_addr  = {32'h0000_0100, 32'h0000_0200};
        bf.m_wstrb = {4'b0011, 4'b1111};
        bf.m_wdata = {32'hD1D1_D1D1, 32'hD0D0_D0D0};
        drive_f(2'b00, 1'b0, 1'b0, 32'h0);

        br.m_req     = 3'b000;
        br.m_wr      = 3'b000;
        br.m_size    = {SZ_WORD, SZ_WORD, SZ_WORD};
        br.m_addr    = {32'h0000_1008, 32'h0000_1004, 32'h0000_1000};
        br.m_wstrb   = '0;
        br.m_wdata   = '0;
        br.s_addr_ok = 1'b0;
        br.s_data_ok = 1'b0;
        br.s_rdata   = '0;

        // Reset state.
        resetn = 1'b0;
        #1;
        chk("rst_s_req_f", 32'(bf.s_req), 32'h0);
        chk("rst_aok_f", 32'(bf.m_addr_ok), 32'h0);
        chk("rst_dok_f", 32'(bf.m_data_ok), 32'h0);
        chk("rst_err_f", 32'(err_f), 32'h0);
        chk("rst_s_req_r", 32'(br.s_req), 32'h0);
        @(negedge clk);
        resetn = 1'b1;

        // Fixed priority, in-order return, full without bypass, empty error.
        vt.push_back(mk(2'b11, 1, 0, 32'h0,  1, 2'b01, 2'b00, 32'h200, 0, 0));
        vt.push_back(mk(2'b11, 1, 0, 32'h0,  1, 2'b01, 2'b00, 32'h200, 0, 0));
        vt.push_back(mk(2'b10, 1, 0, 32'h0,  1, 2'b10, 2'b00, 32'h100, 1, 0));
        vt.push_back(mk(2'b00, 0, 1, 32'h11, 0, 2'b00, 2'b01, 32'h200, 0, 0));
        vt.push_back(mk(2'b00, 0, 1, 32'h22, 0, 2'b00, 2'b01, 32'h200, 0, 0));
        vt.push_back(mk(2'b00, 0, 1, 32'h33, 0, 2'b00, 2'b10, 32'h200, 0, 0));
        vt.push_back(mk(2'b01, 1, 0, 32'h0,  1, 2'b01, 2'b00, 32'h200, 0, 0));
        vt.push_back(mk(2'b01, 1, 0, 32'h0,  1, 2'b01, 2'b00, 32'h200, 0, 0));
        vt.push_back(mk(2'b01, 1, 0, 32'h0,  1, 2'b01, 2'b00, 32'h200, 0, 0));
        vt.push_back(mk(2'b01, 1, 0, 32'h0,  1, 2'b01, 2'b00, 32'h200, 0, 0));
        vt.push_back(mk(2'b01, 1, 0, 32'h0,  0, 2'b00, 2'b00, 32'h200, 0, 0));
        vt.push_back(mk(2'b01, 1, 1, 32'h44, 0, 2'b00, 2'b01, 32'h200, 0, 0));
        vt.push_back(mk(2'b01, 1, 0, 32'h0,  1, 2'b01, 2'b00, 32'h200, 0, 0));
        vt.push_back(mk(2'b00, 0, 1, 32'h55, 0, 2'b00, 2'b01, 32'h200, 0, 0));
        vt.push_back(mk(2'b00, 0, 1, 32'h56, 0, 2'b00, 2'b01, 32'h200, 0, 0));
        vt.push_back(mk(2'b00, 0, 1, 32'h57, 0, 2'b00, 2'b01, 32'h200, 0, 0));
        vt.push_back(mk(2'b00, 0, 1, 32'h58, 0, 2'b00, 2'b01, 32'h200, 0, 0));
        vt.push_back(mk(2'b00, 0, 1, 32'h66, 0, 2'b00, 2'b00, 32'h200, 0, 0));
        vt.push_back(mk(2'b00, 0, 0, 32'h0,  0, 2'b00, 2'b00, 32'h200, 0, 1));

        for (int i = 0; i < vt.size(); i++) begin
            drive_f(vt[i].req, vt[i].aok, vt[i].dok, vt[i].rdata);
            #1;
            chk($sformatf("v%0d_s_req", i), 32'(bf.s_req), 32'(vt[i].exp_sreq));
            chk($sformatf("v%0d_addr_ok", i), 32'(bf.m_addr_ok), 32'(vt[i].exp_aok));
            chk($sformatf("v%0d_data_ok", i), 32'(bf.m_data_ok), 32'(vt[i].exp_dok));
            chk($sformatf("v%0d_s_addr", i), bf.s_addr, vt[i].exp_saddr);
            chk($sformatf("v%0d_s_wr", i), 32'(bf.s_wr), 32'(vt[i].exp_swr));
            chk($sformatf("v%0d_rdata", i), bf.m_rdata, vt[i].rdata);
            chk($sformatf("v%0d_err", i), 32'(err_f), 32'(vt[i].exp_err));
            @(negedge clk);
        end

        // Clear the sticky error.
        drive_f(2'b00, 1'b0, 1'b0, 32'h0);
        pulse_reset();
        chk("clr_err", 32'(err_f), 32'h0);

        // Lock: ch1 stalled three cycles, ch0 arrives but cannot steal.
        for (int c = 0; c < 3; c++) begin
            drive_f(2'b10, 1'b0, 1'b0, 32'h0);
            #1;
            chk($sformatf("lock_wait%0d_s_req", c), 32'(bf.s_req), 32'h1);
            chk($sformatf("lock_wait%0d_s_addr", c), bf.s_addr, 32'h100);
            chk($sformatf("lock_wait%0d_aok", c), 32'(bf.m_addr_ok), 32'h0);
            @(negedge clk);
        end
        drive_f(2'b11, 1'b0, 1'b0, 32'h0);
        #1;
        chk("lock_hold_s_addr", bf.s_addr, 32'h100);
        chk("lock_hold_s_wr", 32'(bf.s_wr), 32'h1);
        chk("lock_hold_s_size", 32'(bf.s_size), 32'(SZ_HALF));
        @(negedge clk);
        drive_f(2'b11, 1'b1, 1'b0, 32'h0);
        #1;
        chk("lock_acc_aok", 32'(bf.m_addr_ok), 32'h2);
        chk("lock_acc_s_addr", bf.s_addr, 32'h100);
        @(negedge clk);
        drive_f(2'b01, 1'b1, 1'b0, 32'h0);
        #1;
        chk("after_lock_aok", 32'(bf.m_addr_ok), 32'h1);
        chk("after_lock_s_addr", bf.s_addr, 32'h200);
        chk("after_lock_wstrb", 32'(bf.s_wstrb), 32'hF);
        @(negedge clk);

        // Ordering: ch1 was accepted first, then ch0.
        drive_f(2'b00, 1'b0, 1'b1, 32'h0000_AAAA);
        #1;
        chk("ord1_dok", 32'(bf.m_data_ok), 32'h2);
        chk("ord1_rdata", bf.m_rdata, 32'h0000_AAAA);
        @(negedge clk);
        drive_f(2'b00, 1'b0, 1'b1, 32'h0000_BBBB);
        #1;
        chk("ord2_dok", 32'(bf.m_data_ok), 32'h1);
        chk("ord2_rdata", bf.m_rdata, 32'h0000_BBBB);
        @(negedge clk);

        // Response with nothing outstanding.
        drive_f(2'b00, 1'b0, 1'b1, 32'h0);
        #1;
        chk("empty_dok", 32'(bf.m_data_ok), 32'h0);
        chk("empty_err_before", 32'(err_f), 32'h0);
        @(negedge clk);
        drive_f(2'b01, 1'b1, 1'b0, 32'h0);
        #1;
        chk("empty_err_after", 32'(err_f), 32'h1);
        @(negedge clk);
        drive_f(2'b01, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        drive_f(2'b00, 1'b0, 1'b0, 32'h0);
        #1;
        chk("two_outst_count", 32'(u_fix.u_fifo.count), 32'h2);

        // Asynchronous reset mid-transaction, between clock edges.
        #1 resetn = 1'b0;
        #1;
        chk("async_rst_err", 32'(err_f), 32'h0);
        chk("async_rst_count", 32'(u_fix.u_fifo.count), 32'h0);
        @(negedge clk);
        resetn = 1'b1;
        drive_f(2'b00, 1'b0, 1'b1, 32'h0);
        #1;
        chk("dropped_dok", 32'(bf.m_data_ok), 32'h0);
        @(negedge clk);
        drive_f(2'b00, 1'b0, 1'b0, 32'h0);
        #1;
        chk("dropped_err", 32'(err_f), 32'h1);
        @(negedge clk);

        // Round-robin over three always-requesting channels.
        br.m_req     = 3'b111;
        br.s_addr_ok = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #1;
            chk($sformatf("rr%0d_aok", c), 32'(br.m_addr_ok), 32'(1) << (c % 3));
            chk($sformatf("rr%0d_s_addr", c), br.s_addr, 32'h1000 + 32'(4 * (c % 3)));
            @(negedge clk);
        end
        // Pointer is back at 0: {1,2} requesting picks 1, then {0,2} picks 2.
        br.m_req = 3'b110;
        #1;
        chk("rr_skip_aok", 32'(br.m_addr_ok), 32'h2);
        @(negedge clk);
        br.m_req = 3'b101;
        #1;
        chk("rr_wrap_aok", 32'(br.m_addr_ok), 32'h4);
        chk("rr_wrap_s_addr", br.s_addr, 32'h1008);
        chk("rr_err", 32'(err_r), 32'h0);
        @(negedge clk);
        br.m_req     = 3'b000;
        br.s_addr_ok = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
